psum_accumulate_sfu: RTL
========================

Name: psum_accumulate_sfu

Overview:
- Special-function unit directly downstream of the weight-stationary controller.
- Started by the controller's sfu_start pulse; reports progress on sfu_active.
- PSUM SRAM holds num_kij partial-sum planes of num_nij words each. Each word carries col lanes of psum_bw.
- For each output pixel the block reads its num_kij partial sums, adds them lane-wise with signed saturation, optionally applies ReLU, and writes one result word to output SRAM.

Parameters:
- col, 8, lanes per PSUM word (PE columns)
- psum_bw, 16, signed bit-width of each lane
- ADDR_W, 11, SRAM address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- sfu_start  in  1  one-cycle start pulse
- num_nij  in  8  outputs per plane; sampled on accepted start
- num_kij  in  8  planes to accumulate; sampled on accepted start
- psum_base_addr  in  ADDR_W  address of plane 0, output 0; sampled on start
- out_base_addr  in  ADDR_W  first output SRAM address; sampled on start
- relu_en  in  1  1 = clamp negative lanes to 0; sampled on start
- sfu_active  out  1  high while an operation is in progress
- sfu_done  out  1  one-cycle pulse after the final write
- psum_rd_en  out  1  PSUM SRAM read strobe
- psum_rd_addr  out  ADDR_W  PSUM read address
- psum_rd_data  in  col*psum_bw  read data, valid exactly 1 cycle after psum_rd_en
- out_wr_en  out  1  output SRAM write strobe
- out_wr_addr  out  ADDR_W  output write address
- out_wr_data  out  col*psum_bw  lane i at bits [i*psum_bw +: psum_bw]

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; all outputs 0; counters and accumulators cleared. Reset asserted mid-operation aborts immediately. No sfu_done pulse is produced.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: sfu_start = 1 latches the config. Next cycle sfu_active = 1.
  - If num_nij == 0 or num_kij == 0, go to DONE.
  - Otherwise go to READ with o = 0, k = 0.
- READ, one cycle per k:
  - psum_rd_en = 1, psum_rd_addr = psum_base_addr + k*num_nij + o.
  - k increments each cycle; after k == num_kij-1, go to DRAIN.
- Accumulation:
  - The accumulator lanes are loaded, not added, with data returned for k == 0.
  - Later returns are added lane-wise as signed values.
  - Any sum outside the signed psum_bw range saturates to max or min.
- DRAIN: absorbs the last read return (1 cycle). Go to WRITE.
- WRITE:
  - out_wr_en = 1, out_wr_addr = out_base_addr + o.
  - out_wr_data = accumulator, with negative lanes set to 0 when relu_en.
  - If o == num_nij-1, go to DONE; otherwise o++, k = 0, go to READ.
- DONE: sfu_done = 1 for 1 cycle, then IDLE. sfu_active falls in the same cycle the state becomes IDLE.
- Timing: per output, num_kij + 2 cycles. Total active cycles = num_nij*(num_kij+2) + 1.
- Address arithmetic is computed in ADDR_W bits and wraps modulo 2^ADDR_W.
- sfu_start while sfu_active is ignored; config changes mid-run have no effect.
- psum_rd_en and out_wr_en are never high in the same cycle.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package: state encoding localparams and a lane-saturating-add function (signed, psum_bw).
- One sub-module: psum_lane_alu. It is col instances' worth of lane logic: saturating add, load-vs-accumulate select, ReLU on output.
- The FSM and counters stay in the top module.

Test Plan:
- Basic accumulation:
  - Stimulus: num_nij=2, num_kij=3, psum_base=0, out_base=100, relu_en=0. Lane 0 at addrs 0,2,4 = 5,-2,7; at addrs 1,3,5 = 1,1,1.
  - Response: write addr 100 lane0 = 10, addr 101 lane0 = 3; sfu_active high exactly 11 cycles; one sfu_done pulse.
- ReLU:
  - Stimulus: as above with addr 0 lane0 = -20 and relu_en=1.
  - Response: addr 100 lane0 = 0; other lanes unaffected.
- Saturation:
  - Stimulus: psum_bw=16, num_kij=2, lane values 30000 + 10000.
  - Response: lane = 32767. With -30000 + -10000, lane = -32768.
- Zero config:
  - Stimulus: num_nij=0.
  - Response: no rd/wr strobes; sfu_active high 1 cycle; sfu_done pulse.
- Robustness:
  - Stimulus: sfu_start re-pulsed mid-run → ignored, results unchanged.
  - Stimulus: reset low mid-READ → all outputs 0 immediately, no sfu_done. A new start afterwards completes correctly.
- Address wrap:
  - Stimulus: psum_base=2046, num_nij=1, num_kij=3.
  - Response: read addresses 2046, 2047, 0.

Source files
------------

// File: rtl/psum_accumulate_sfu_pkg.sv
// Shared types and arithmetic for the partial-sum accumulation SFU.
package psum_accumulate_sfu_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StDrain = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } sfu_state_e;

    // Signed add clamped to the range of a bw-bit two's-complement lane (bw <= 31).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        bw);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (bw - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (bw - 1));
        if (sum > hi) begin
            return 32'(hi);
        end else if (sum < lo) begin
            return 32'(lo);
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// Per-lane accumulate datapath: load-or-saturating-add, plus a ReLU view of the result.
module psum_lane_alu
    import psum_accumulate_sfu_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
) (
    input  logic [col*psum_bw-1:0] acc_i,
    input  logic [col*psum_bw-1:0] data_i,
    input  logic                   load_i,
    input  logic                   relu_i,
    output logic [col*psum_bw-1:0] acc_o,
    output logic [col*psum_bw-1:0] relu_o
);

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic signed [psum_bw-1:0] a;
        logic signed [psum_bw-1:0] d;
        logic signed [psum_bw-1:0] nxt;

        assign a   = acc_i[i*psum_bw +: psum_bw];
        assign d   = data_i[i*psum_bw +: psum_bw];
        assign nxt = load_i ? d : psum_bw'(sat_add(32'(a), 32'(d), psum_bw));

        assign acc_o[i*psum_bw +: psum_bw]  = nxt;
        assign relu_o[i*psum_bw +: psum_bw] = (relu_i && nxt[psum_bw-1]) ? '0 : nxt;
    end

endmodule

// File: rtl/psum_accumulate_sfu.sv
// Sums num_kij partial-sum planes per output pixel and writes one saturated (optionally
// ReLU'd) word per pixel. The FSM, counters and all output registers live here.
module psum_accumulate_sfu
    import psum_accumulate_sfu_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned ADDR_W  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sfu_start,
    input  logic [7:0]             num_nij,
    input  logic [7:0]             num_kij,
    input  logic [ADDR_W-1:0]      psum_base_addr,
    input  logic [ADDR_W-1:0]      out_base_addr,
    input  logic                   relu_en,
    output logic                   sfu_active,
    output logic                   sfu_done,
    output logic                   psum_rd_en,
    output logic [ADDR_W-1:0]      psum_rd_addr,
    input  logic [col*psum_bw-1:0] psum_rd_data,
    output logic                   out_wr_en,
    output logic [ADDR_W-1:0]      out_wr_addr,
    output logic [col*psum_bw-1:0] out_wr_data
);

    localparam int unsigned DW = col * psum_bw;

    sfu_state_e        state_q, state_d;
    logic [7:0]        nij_q, nij_d, kij_q, kij_d, k_q, k_d, o_q, o_d;
    logic              relu_q, relu_d;
    logic [ADDR_W-1:0] row_q, row_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic              rd_pend_q, rd_first_q;
    logic [DW-1:0]     acc_q, out_q, acc_nxt, relu_nxt;
    logic              active_q, done_q, rd_en_q, wr_en_q;

    // row_q is the plane-0 address of the current pixel; rd_addr_q strides by num_nij.
    always_comb begin
        state_d   = state_q;
        nij_d     = nij_q;
        kij_d     = kij_q;
        relu_d    = relu_q;
        k_d       = k_q;
        o_d       = o_q;
        row_d     = row_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (sfu_start) begin
                    nij_d     = num_nij;
                    kij_d     = num_kij;
                    relu_d    = relu_en;
                    k_d       = 8'd0;
                    o_d       = 8'd0;
                    row_d     = psum_base_addr;
                    rd_addr_d = psum_base_addr;
                    wr_addr_d = out_base_addr;
                    state_d   = (num_nij == 8'd0 || num_kij == 8'd0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (k_q == kij_q - 8'd1) begin
                    state_d = StDrain;
                end else begin
                    k_d       = k_q + 8'd1;
                    rd_addr_d = rd_addr_q + ADDR_W'(nij_q);
                end
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                if (o_q == nij_q - 8'd1) begin
                    state_d = StDone;
                end else begin
                    o_d       = o_q + 8'd1;
                    k_d       = 8'd0;
                    row_d     = row_q + ADDR_W'(1);
                    rd_addr_d = row_q + ADDR_W'(1);
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    state_d   = StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    psum_lane_alu #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_alu (
        .acc_i  (acc_q),
        .data_i (psum_rd_data),
        .load_i (rd_first_q),
        .relu_i (relu_q),
        .acc_o  (acc_nxt),
        .relu_o (relu_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            nij_q      <= '0;
            kij_q      <= '0;
            relu_q     <= 1'b0;
            k_q        <= '0;
            o_q        <= '0;
            row_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_first_q <= 1'b0;
            acc_q      <= '0;
            out_q      <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            nij_q      <= nij_d;
            kij_q      <= kij_d;
            relu_q     <= relu_d;
            k_q        <= k_d;
            o_q        <= o_d;
            row_q      <= row_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            // Read data lands one cycle after the strobe; remember whether it is plane 0.
            rd_pend_q  <= (state_q == StRead);
            rd_first_q <= (k_q == 8'd0);
            if (rd_pend_q) begin
                acc_q <= acc_nxt;
            end
            if (state_q == StDrain) begin
                out_q <= relu_nxt;
            end
            active_q   <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            rd_en_q    <= (state_d == StRead);
            wr_en_q    <= (state_d == StWrite);
        end
    end

    assign sfu_active   = active_q;
    assign sfu_done     = done_q;
    assign psum_rd_en   = rd_en_q;
    assign psum_rd_addr = rd_addr_q;
    assign out_wr_en    = wr_en_q;
    assign out_wr_addr  = wr_addr_q;
    assign out_wr_data  = out_q;

endmodule
